// File: rtl/pm_meas_pkg.sv
// pm_meas_pkg: shared FSM states and sizing constants for the phase-monitor measurement controller
package pm_meas_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, DONE} state_t;
  localparam int CLR_CYCLES_DEF = 8;
  localparam int ACC_GUARD = 7;
  function automatic int acc_width(input int n_pm);
    return n_pm + ACC_GUARD;
  endfunction
endpackage

// File: rtl/pm_wait_timer.sv
// pm_wait_timer: loadable down-counter whose done flag is high once the count reaches zero
module pm_wait_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  end
  assign done = (cnt == '0);
endmodule

// File: rtl/pm_meas_ctrl.sv
// pm_meas_ctrl: sequences clear/run/capture cycles of a phase monitor and averages 2^n runs
module pm_meas_ctrl
  import pm_meas_pkg::*;
#(
  parameter int N_PM       = 20,
  parameter int WAIT_W     = 24,
  parameter int CLR_CYCLES = CLR_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WAIT_W-1:0] wait_cycles,
  input  logic [2:0]        n_avg_log2,
  input  logic [N_PM-1:0]   pm_out,
  output logic              en_pm,
  output logic              busy,
  output logic [N_PM-1:0]   result,
  output logic              result_valid,
  input  logic              result_ready
);
  localparam int AW = acc_width(N_PM);
  state_t state, nxt;
  logic [WAIT_W-1:0] wait_lat, t_val, run_len;
  logic [2:0] n_lat;
  logic [AW-1:0] acc, acc_sum;
  logic [7:0] runs;
  logic [8:0] runs_nxt;
  logic t_load, t_done, last;
  pm_wait_timer #(.W(WAIT_W)) u_timer (
    .clk(clk), .rst(rst), .load(t_load), .load_val(t_val), .done(t_done)
  );
  assign acc_sum = acc + AW'(pm_out);
  assign runs_nxt = {1'b0, runs} + 9'd1;
  assign last = (runs_nxt == (9'd1 << n_lat));
  // a zero window is stretched to one cycle by loading 0 instead of wrapping
  assign run_len = (wait_lat == '0) ? '0 : wait_lat - WAIT_W'(1);
  assign busy = (state != IDLE);
  assign result_valid = (state == DONE);
  always_comb begin
    nxt = state;
    t_load = 1'b0;
    t_val = WAIT_W'(CLR_CYCLES - 1);
    case (state)
      IDLE: if (start) begin
        nxt = CLEAR;
        t_load = 1'b1;
      end
      CLEAR: if (abort) nxt = IDLE;
        else if (t_done) begin
          nxt = RUN;
          t_load = 1'b1;
          t_val = run_len;
        end
      RUN: nxt = abort ? IDLE : t_done ? CAPTURE : RUN;
      CAPTURE: begin
        nxt = abort ? IDLE : last ? DONE : CLEAR;
        t_load = !abort && !last;
      end
      DONE: nxt = result_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      en_pm <= 1'b0;
      result <= '0;
      acc <= '0;
      runs <= '0;
      wait_lat <= '0;
      n_lat <= '0;
    end else begin
      state <= nxt;
      en_pm <= (nxt == RUN) || (nxt == CAPTURE);
      if (state == IDLE && start) begin
        wait_lat <= wait_cycles;
        n_lat <= n_avg_log2;
        acc <= '0;
        runs <= '0;
      end
      if (state == CAPTURE) begin
        acc <= acc_sum;
        runs <= runs_nxt[7:0];
      end
      if (state == CAPTURE && nxt == DONE) result <= N_PM'(acc_sum >> n_lat);
    end
  end
endmodule

// File: tb/tb_pm_meas_ctrl.sv
// tb_pm_meas_ctrl: scenario tasks with a result scoreboard for pm_meas_ctrl
module tb_pm_meas_ctrl;
  logic clk = 0, rst = 1, start = 0, abort = 0, result_ready = 0;
  logic [23:0] wait_cycles = '0;
  logic [2:0] n_avg_log2 = '0;
  logic [19:0] pm_out = '0;
  logic en_pm, busy, result_valid;
  logic [19:0] result;
  int errors = 0, checks = 0;
  int pm_base = 0, pm_step = 0, run_idx = 0;
  logic prev_en = 0;
  logic [19:0] exp_q[$];

  pm_meas_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .wait_cycles(wait_cycles),
    .n_avg_log2(n_avg_log2), .pm_out(pm_out), .en_pm(en_pm), .busy(busy),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  // phase-monitor stand-in: value advances by pm_step after every completed run
  always @(negedge clk) begin
    if (prev_en && !en_pm) run_idx++;
    prev_en = en_pm;
    pm_out = 20'(pm_base + pm_step * run_idx);
  end

  task automatic begin_meas(input int w, input int n, input int base, input int step, input bit expect_result);
    pm_base = base;
    pm_step = step;
    run_idx = 0;
    @(negedge clk);
    wait_cycles = 24'(w);
    n_avg_log2 = 3'(n);
    start = 1;
    if (expect_result) exp_q.push_back(20'(base + step * ((1 << n) - 1) / 2));
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (!result_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!result_valid) begin
      errors++;
      $display("FAIL %s timeout: result_valid=%b required 1", name, result_valid);
    end
  endtask

  task automatic check_result(input string name);
    logic [19:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: result=%0d but scoreboard empty", name, result);
    end else begin
      exp = exp_q.pop_front();
      if (result !== exp) begin
        errors++;
        $display("FAIL %s: result=%0d required %0d", name, result, exp);
      end
    end
  endtask

  task automatic handshake(input string name);
    result_ready = 1;
    @(negedge clk);
    result_ready = 0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake: busy=%b valid=%b required 0 0", name, busy, result_valid);
    end
  endtask

  task automatic check_idle_outputs(input string name, input logic [19:0] exp_res);
    checks++;
    if ({en_pm, busy, result_valid} !== 3'b000 || result !== exp_res) begin
      errors++;
      $display("FAIL %s: en_pm=%b busy=%b valid=%b result=%0d required 0 0 0 %0d",
               name, en_pm, busy, result_valid, result, exp_res);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    start = 1;
    abort = 1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset", 20'd0);
    rst = 0;
    start = 0;
    abort = 0;
  endtask

  task automatic test_single();
    int lo = 0, hi = 0;
    begin_meas(100, 0, 12345, 0, 1);
    while (!en_pm && lo < 1000) begin
      lo++;
      @(negedge clk);
    end
    while (en_pm && hi < 1000) begin
      hi++;
      @(negedge clk);
    end
    checks++;
    if (lo != 8) begin
      errors++;
      $display("FAIL single clear_len: got %0d cycles required 8", lo);
    end
    checks++;
    if (hi != 101) begin
      errors++;
      $display("FAIL single run_len: got %0d cycles required 101", hi);
    end
    wait_valid(10, "single");
    check_result("single");
    handshake("single");
  endtask

  task automatic test_average4();
    int rises = 0, n = 0;
    logic p = 0;
    begin_meas(5, 2, 1000, 1, 1);
    wait_cycles = 24'd300;
    n_avg_log2 = 3'd7;
    while (!result_valid && n < 500) begin
      if (en_pm && !p) rises++;
      p = en_pm;
      @(negedge clk);
      n++;
    end
    checks++;
    if (rises != 4) begin
      errors++;
      $display("FAIL avg4 runs: got %0d runs required 4", rises);
    end
    wait_valid(10, "avg4");
    check_result("avg4");
    handshake("avg4");
  endtask

  task automatic test_average128();
    begin_meas(1, 7, 1048575, 0, 1);
    wait_valid(3000, "avg128");
    check_result("avg128");
    handshake("avg128");
  endtask

  task automatic test_hold();
    logic [19:0] held;
    int bad = 0;
    begin_meas(3, 1, 777, 2, 1);
    wait_valid(200, "hold");
    held = result;
    for (int i = 0; i < 50; i++) begin
      start = (i == 20);
      @(negedge clk);
      if (result !== held || result_valid !== 1'b1 || busy !== 1'b1) bad++;
    end
    start = 0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold stability: %0d unstable cycles required 0", bad);
    end
    check_result("hold");
    start = 1;
    handshake("hold");
    start = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_at_handshake: busy=%b required 0", busy);
    end
  endtask

  task automatic test_abort();
    logic [19:0] prev;
    int n = 0;
    prev = result;
    begin_meas(10, 0, 55, 0, 0);
    while (!en_pm && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check_idle_outputs("abort", prev);
    repeat (15) @(negedge clk);
    check_idle_outputs("abort_stays_idle", prev);
  endtask

  task automatic test_rst_and_zero_wait();
    int n = 0, hi = 0;
    begin_meas(50, 0, 99, 0, 0);
    while (!en_pm && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_idle_outputs("rst_mid_run", 20'd0);
    begin_meas(0, 0, 4321, 0, 1);
    n = 0;
    while (!en_pm && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (en_pm && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    checks++;
    if (hi != 2) begin
      errors++;
      $display("FAIL zero_wait run_len: got %0d cycles required 2", hi);
    end
    wait_valid(10, "zero_wait");
    check_result("zero_wait");
    handshake("zero_wait");
  endtask

  initial begin
    test_reset();
    test_single();
    test_average4();
    test_average128();
    test_hold();
    test_abort();
    test_rst_and_zero_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pm_meas_ctrl.md
PM_MEAS_CTRL -- requirements
Module: pm_meas_ctrl

Interface
REQ-001 Parameter: N_PM, 20, width of the phase-monitor count pm_out.
REQ-002 Parameter: WAIT_W, 24, width of the measurement-window timer.
REQ-003 Parameter: CLR_CYCLES, 8, number of cycles en_pm is held low before each run.
REQ-004 Port: clk  in  1  single clock; all logic is on its rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: start  in  1  request a measurement; sampled only in IDLE.
REQ-007 Port: abort  in  1  cancel any measurement in progress.
REQ-008 Port: wait_cycles  in  WAIT_W  en_pm-high window length per run, in clk cycles.
REQ-009 Port: n_avg_log2  in  3  runs per measurement = 2^n_avg_log2, giving 1 to 128 runs.
REQ-010 Port: pm_out  in  N_PM  count from phase_monitor.
REQ-011 Port: en_pm  out  1  enable to phase_monitor; low clears its counter.
REQ-012 Port: busy  out  1  high in every state except IDLE.
REQ-013 Port: result  out  N_PM  averaged pm_out.
REQ-014 Port: result_valid  out  1  result handshake valid.
REQ-015 Port: result_ready  in  1  result handshake ready.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, RUN, CAPTURE and DONE.
REQ-017 In IDLE, start=1 SHALL latch wait_cycles and n_avg_log2, zero the accumulator and run counter, and move to CLEAR.
REQ-018 In CLEAR, en_pm SHALL be 0 for exactly CLR_CYCLES cycles, then the FSM SHALL move to RUN.
REQ-019 In RUN, en_pm SHALL be 1 for exactly max(wait_cycles,1) cycles; a latched value of 0 SHALL be treated as 1.
REQ-020 In CAPTURE (one cycle, en_pm=1), the FSM SHALL add pm_out to an accumulator N_PM+7 bits wide and increment the run counter.
REQ-021 After CAPTURE, the FSM SHALL return to CLEAR if runs < 2^n_avg_log2; otherwise it SHALL go to DONE.
REQ-022 On entry to DONE, result SHALL equal accumulator >> n_avg_log2 (truncating) and result_valid SHALL be 1.
REQ-023 result and result_valid SHALL hold stable until result_ready=1 is seen; the FSM SHALL then go to IDLE with result_valid=0.
REQ-024 result SHALL hold its last value in IDLE.
REQ-025 Changes to wait_cycles or n_avg_log2 while busy SHALL have no effect on the measurement in progress.
REQ-026 start while busy SHALL be ignored.
REQ-027 start in the same cycle as the DONE handshake SHALL be ignored; a new start is accepted only from IDLE.
REQ-028 abort=1 in CLEAR, RUN or CAPTURE SHALL force the FSM to IDLE next cycle with en_pm=0 and result/result_valid unchanged.
REQ-029 abort SHALL have no effect in IDLE or DONE.
REQ-030 When abort and the CAPTURE-to-DONE transition occur in the same cycle, abort SHALL win.
REQ-031 en_pm SHALL be registered, with no combinational path from any input to any output.
REQ-032 Timing: a start accepted at edge k gives en_pm=0 over cycles k+1 to k+CLR_CYCLES and en_pm=1 from k+CLR_CYCLES+1.

Reset
REQ-033 rst=1 SHALL force IDLE, en_pm=0, busy=0, result=0, result_valid=0, accumulator=0 and run counter=0 on the next edge.
REQ-034 Reset SHALL override abort, start and any in-flight measurement in any state.

Structure
REQ-035 A shared package pm_meas_pkg SHALL hold the state enum, the CLR_CYCLES default and the accumulator-width constant (N_PM+7).
REQ-036 One sub-module, pm_wait_timer, SHALL be instantiated: a loadable WAIT_W-bit down-counter with a done flag, reused for both the CLEAR and RUN intervals.

Verification
REQ-037 Bench: wait_cycles=100, n_avg_log2=0, pm_out held at 12345 -> en_pm low 8 cycles, high 101 cycles, then result=12345 with result_valid=1.
REQ-038 Bench: n_avg_log2=2, pm_out=1000, 1001, 1002, 1003 per run -> four CLEAR/RUN cycles, then result=1001.
REQ-039 Bench: n_avg_log2=7, pm_out=2^20-1 every run -> result=1048575, with no accumulator overflow.
REQ-040 Bench: hold result_ready=0 for 50 cycles in DONE -> result and result_valid stable, busy=1, and a start pulse in that window is ignored.
REQ-041 Bench: abort during the 3rd RUN cycle -> IDLE next cycle, en_pm=0, result_valid=0, previous result retained.
REQ-042 Bench: rst pulse mid-RUN, and wait_cycles=0 -> all outputs zero after reset; a wait_cycles=0 run gives en_pm high for 1 cycle plus the capture cycle.
